// File: rtl/interrupt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_arbiter_pkg
// Brief    : Shared state encoding, PC width and ISR address defaults.
// Revision : 1.0
// ============================================================================
package interrupt_arbiter_pkg;

    localparam int PC_W = 12;
    localparam int ID_W = 3;

    localparam logic [PC_W-1:0] ISR_BASE_DEF   = 12'h100;
    localparam logic [PC_W-1:0] ISR_STRIDE_DEF = 12'h010;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_SERVICE = 2'd2;

    // Entry PC wraps modulo the 12-bit PC space
    function automatic logic [PC_W-1:0] isr_entry(
        input logic [PC_W-1:0] base,
        input logic [PC_W-1:0] stride,
        input logic [ID_W-1:0] id
    );
        return base + PC_W'(id) * stride;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_arbiter_prio_encoder.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_arbiter_prio_encoder
// Brief    : Combinational lowest-index-first priority encoder.
// Revision : 1.0
// ============================================================================
module interrupt_arbiter_prio_encoder
    import interrupt_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    // Scan high to low so the lowest set index is the last assignment
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_arbiter
// Brief    : Edge-latching, maskable, fixed-priority interrupt arbiter with
//            single-level request/service handshake.
// Revision : 1.0
// ============================================================================
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int              NUM_SRC    = 4,
    parameter logic [PC_W-1:0] ISR_BASE   = ISR_BASE_DEF,
    parameter logic [PC_W-1:0] ISR_STRIDE = ISR_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [PC_W-1:0]    isr_addr,
    output logic [ID_W-1:0]    active_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] enable
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SRC-1:0]   r_irq_prev;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_enable;
    logic [ID_W-1:0]      r_active_id;
    logic [PC_W-1:0]      r_isr_addr;
    logic [NUM_SRC-1:0]   w_rise;
    logic [NUM_SRC-1:0]   w_clr;
    logic [NUM_SRC-1:0]   w_eligible;
    logic                 w_valid;
    logic [ID_W-1:0]      w_idx;
    logic                 w_accept;

    assign w_rise     = irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_enable;
    assign w_accept   = (r_state == ST_REQ) && int_ack;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = w_accept && (r_active_id == ID_W'(i));
        end
    end

    interrupt_arbiter_prio_encoder #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req   (w_eligible),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // A new edge on the bit being acknowledged keeps it pending
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_enable   <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_enable <= mask_wdata;
            end
        end
    end

    // Winner is frozen on leaving IDLE and held through REQ and SERVICE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_active_id <= '0;
            r_isr_addr  <= ISR_BASE;
        end else if ((r_state == ST_IDLE) && w_valid) begin
            r_active_id <= w_idx;
            r_isr_addr  <= isr_entry(ISR_BASE, ISR_STRIDE, w_idx);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IDLE always lasts at least one cycle after a return, giving the gap
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_valid) w_state_nxt = ST_REQ;
            ST_REQ:     if (int_ack) w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (int_ret) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req    = (r_state == ST_REQ);
        in_service = (r_state == ST_SERVICE);
    end

    assign isr_addr  = r_isr_addr;
    assign active_id = r_active_id;
    assign pending   = r_pending;
    assign enable    = r_enable;

endmodule
`default_nettype wire
